// File: rtl/async_fifo_wr_ctrl_if.sv
// async_fifo_wr_ctrl_if: write-side push/flag bundle between the FIFO user and the write controller
interface async_fifo_wr_ctrl_if #(parameter int ADDR_W = 4);
    logic              winc;
    logic [ADDR_W:0]   rgray_sync;
    logic              clr_ovf;
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W:0]   wgray;
    logic              full;
    logic              almost_full;
    logic [ADDR_W:0]   wlevel;
    logic              overflow;
    modport master (
        output winc, rgray_sync, clr_ovf,
        input  wen, waddr, wgray, full, almost_full, wlevel, overflow
    );
    modport slave (
        input  winc, rgray_sync, clr_ovf,
        output wen, waddr, wgray, full, almost_full, wlevel, overflow
    );
endinterface

// File: rtl/async_fifo_wr_ctrl.sv
// async_fifo_wr_ctrl: write-pointer sequencer with full/almost-full, level and sticky overflow
module async_fifo_wr_ctrl #(
    parameter int ADDR_W       = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    async_fifo_wr_ctrl_if.slave  bus
);
    localparam logic [ADDR_W:0] AF = AFULL_THRESH[ADDR_W:0];
    logic [ADDR_W:0] r_wbin, r_wgray, r_wlevel;
    logic            r_full, r_afull, r_ovf;
    logic            w_wen;
    logic [ADDR_W:0] w_wbin_next, w_wgray_next, w_rbin, w_level_next, w_full_gray;
    assign w_wen        = bus.winc & ~r_full;
    assign w_wbin_next  = r_wbin + {{ADDR_W{1'b0}}, w_wen};
    assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);
    // Each binary bit is the XOR of all Gray bits at or above it
    for (genvar i = 0; i <= ADDR_W; i++) begin : g_g2b
        assign w_rbin[i] = ^bus.rgray_sync[ADDR_W:i];
    end
    assign w_full_gray  = {~bus.rgray_sync[ADDR_W:ADDR_W-1], bus.rgray_sync[ADDR_W-2:0]};
    assign w_level_next = w_wbin_next - w_rbin;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wbin   <= '0;
            r_wgray  <= '0;
            r_wlevel <= '0;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_wbin   <= w_wbin_next;
            r_wgray  <= w_wgray_next;
            r_wlevel <= w_level_next;
            r_full   <= w_wgray_next == w_full_gray;
            r_afull  <= w_level_next >= AF;
            r_ovf    <= (bus.winc & r_full) | (r_ovf & ~bus.clr_ovf);
        end
    end
    assign bus.wen         = w_wen;
    assign bus.waddr       = r_wbin[ADDR_W-1:0];
    assign bus.wgray       = r_wgray;
    assign bus.full        = r_full;
    assign bus.almost_full = r_afull;
    assign bus.wlevel      = r_wlevel;
    assign bus.overflow    = r_ovf;
endmodule
